exp_align: RTL and testbench

EXP_ALIGN -- requirements
Module: exp_align

---
 rtl/exp_align.sv | 141 ++++++++++++++
 tb/tb_exp_align.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp_align.sv
// Block-floating-point exponent aligner: collects N operands, then emits each one
// shifted to the group's largest exponent as a 20-bit two's-complement value.
module exp_align #(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sign,
   input  logic [10:0]        in_mant,
   input  logic signed [5:0]  in_exp,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [19:0] out_data,
   output logic signed [5:0]  exp_max,
   output logic               out_last
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]       LAST_IDX = IW'(N - 1);
   localparam logic signed [5:0]   EXP_ZERO = 6'sb100000;

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   state_t                state_r, state_s;
   logic [IW-1:0]         idx_r, idx_s;
   logic signed [5:0]     exp_max_r, exp_max_s;
   logic                  sign_buf_r [N];
   logic [10:0]           mant_buf_r [N];
   logic signed [5:0]     exp_buf_r  [N];
   logic                  in_ready_r, out_valid_r, out_last_r;
   logic [19:0]           out_data_r;
   logic                  out_valid_s, in_ready_s, out_last_s;
   logic [19:0]           out_data_s;

   // Shift the implied-one mantissa down by the exponent gap and apply the sign.
   function automatic logic [19:0] align_operand(
      input logic              sign,
      input logic [10:0]       mant,
      input logic signed [5:0] e,
      input logic signed [5:0] emax
   );
      logic [6:0]  d;
      logic [15:0] mag;
      logic [19:0] ext;
      d   = {emax[5], emax} - {e[5], e};
      mag = ((e == EXP_ZERO) || (d >= 7'd16)) ? 16'd0 : ({1'b1, mant, 4'b0000} >> d[3:0]);
      ext = {4'b0000, mag};
      return sign ? (20'd0 - ext) : ext;
   endfunction

   // Next-state, index and running-maximum logic plus next values of the output registers.
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      exp_max_s = exp_max_r;
      case (state_r)
         COLLECT: begin
            if (in_valid) begin
               // -32 is the smallest code, so a plain signed max already ignores zeros
               if ((idx_r == {IW{1'b0}}) || (in_exp > exp_max_r)) begin
                  exp_max_s = in_exp;
               end else begin
                  exp_max_s = exp_max_r;
               end
               if (idx_r == LAST_IDX) begin
                  idx_s   = {IW{1'b0}};
                  state_s = EMIT;
               end else begin
                  idx_s = idx_r + IW'(1);
               end
            end else begin
               idx_s = idx_r;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (idx_r == LAST_IDX) begin
                  idx_s   = {IW{1'b0}};
                  state_s = COLLECT;
               end else begin
                  idx_s = idx_r + IW'(1);
               end
            end else begin
               idx_s = idx_r;
            end
         end
         default: begin
            state_s = COLLECT;
            idx_s   = {IW{1'b0}};
         end
      endcase
      in_ready_s  = (state_s == COLLECT);
      out_valid_s = (state_s == EMIT);
      out_last_s  = (state_s == EMIT) && (idx_s == LAST_IDX);
      if (state_s == EMIT) begin
         out_data_s = align_operand(sign_buf_r[idx_s], mant_buf_r[idx_s], exp_buf_r[idx_s], exp_max_s);
      end else begin
         out_data_s = 20'd0;
      end
   end

   // State, operand buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= COLLECT;
         idx_r       <= {IW{1'b0}};
         exp_max_r   <= EXP_ZERO;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= 20'd0;
         for (int i = 0; i < N; i++) begin
            sign_buf_r[i] <= 1'b0;
            mant_buf_r[i] <= 11'd0;
            exp_buf_r[i]  <= EXP_ZERO;
         end
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         exp_max_r   <= exp_max_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
         out_last_r  <= out_last_s;
         out_data_r  <= out_data_s;
         if ((state_r == COLLECT) && in_valid) begin
            sign_buf_r[idx_r] <= in_sign;
            mant_buf_r[idx_r] <= in_mant;
            exp_buf_r[idx_r]  <= in_exp;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_data  = out_data_r;
   assign exp_max   = exp_max_r;

endmodule

// File: tb/tb_exp_align.sv
// Randomized scoreboard bench for exp_align: the driver pushes expected aligned
// values computed arithmetically per group; a negedge monitor pops and compares.
module tb_exp_align;
   localparam int N = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               in_sign = 1'b0;
   logic [10:0]        in_mant = 11'd0;
   logic signed [5:0]  in_exp = 6'sb100000;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [19:0] out_data;
   logic signed [5:0]  exp_max;
   logic               out_last;

   typedef struct {int data; int last; int emax;} exp_t;
   exp_t sb[$];
   bit   gs[$];
   int   gm[$];
   int   ge[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_pops = 0;
   bit mon_en = 1'b0;
   bit rdy_force = 1'b1;
   bit rdy_val = 1'b1;
   bit held = 1'b0;
   int h_data, h_last, h_emax;

   exp_align #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_mant(in_mant), .in_exp(in_exp),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .exp_max(exp_max), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h required 'h%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: value = 1.mant * 2^(e-emax) scaled by 2^15, truncated.
   function automatic int ref_val(input bit s, input int m, input int e, input int emax);
      int d, mag;
      if (e == -32) return 0;
      d = emax - e;
      if (d >= 16) return 0;
      mag = ((2048 + m) * 16) / (1 << d);
      return (s ? -mag : mag) & 32'hFFFFF;
   endfunction

   function automatic bit accept(input bit s, input int m, input int e);
      int   emax;
      exp_t x;
      gs.push_back(s); gm.push_back(m); ge.push_back(e);
      if (gs.size() < N) return 1'b0;
      emax = -32;
      foreach (ge[i]) if (ge[i] != -32 && ge[i] > emax) emax = ge[i];
      for (int i = 0; i < N; i++) begin
         x.data = ref_val(gs[i], gm[i], ge[i], emax);
         x.last = (i == N - 1) ? 1 : 0;
         x.emax = emax;
         sb.push_back(x);
      end
      gs.delete(); gm.delete(); ge.delete();
      return 1'b1;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the operand is taken.
   task automatic send(input bit s, input logic [10:0] m, input logic signed [5:0] e);
      int waited = 0;
      bit done = 1'b0;
      bit grp = 1'b0;
      in_valid = 1'b1; in_sign = s; in_mant = m; in_exp = e;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            grp = accept(s, int'(m), int'(e));
         end else if (waited > 300) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
            done = 1'b1;
         end
         waited++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (grp) begin
         @(negedge clk);
         chk("latency_out_valid", int'(out_valid), 1);
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 1000) begin
         @(posedge clk); k++;
      end
      #1;
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d outputs outstanding, 0 required", sb.size());
      end
   endtask

   // Ready generator: forced value or random back-pressure, changed mid-cycle.
   initial forever begin
      @(posedge clk); #2;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
   end

   // Monitor: pop on every handshake, and check stability while stalled.
   always @(negedge clk) begin
      if (mon_en && out_valid) begin
         chk("in_ready_in_emit", int'(in_ready), 0);
         if (held) begin
            chk("hold_data", int'({12'd0, out_data}), h_data);
            chk("hold_last", int'(out_last), h_last);
            chk("hold_exp_max", int'(exp_max), h_emax);
         end
         if (out_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_output: data 'h%0h with no expected value", out_data);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("out_data", int'({12'd0, out_data}), x.data);
               chk("out_last", int'(out_last), x.last);
               chk("exp_max", int'(exp_max), x.emax);
            end
            n_pops++;
         end else begin
            held = 1'b1;
            h_data = int'({12'd0, out_data}); h_last = int'(out_last); h_emax = int'(exp_max);
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      int ei, base;
      logic signed [5:0] e;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_data", int'({12'd0, out_data}), 0);
      chk("rst_exp_max", int'(exp_max), -32);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Mixed exponents, sign=1 with other operands zero, d>=16, all-zero group
      send(1'b0, 11'd0, 6'sd3);  send(1'b0, 11'd0, 6'sd1);
      send(1'b0, 11'd0, 6'sd3);  send(1'b0, 11'd0, -6'sd2);
      drain();
      send(1'b1, 11'h400, 6'sd0); send(1'b1, 11'h7FF, 6'sb100000);
      send(1'b0, 11'h123, 6'sb100000); send(1'b1, 11'd0, 6'sb100000);
      drain();
      send(1'b0, 11'd0, 6'sd20); send(1'b0, 11'd0, 6'sd3);
      send(1'b0, 11'd0, 6'sd20); send(1'b0, 11'd0, 6'sd20);
      drain();
      repeat (N) send(1'b0, 11'd0, 6'sb100000);
      drain();

      // Stall three cycles while the second value is presented
      send(1'b0, 11'h055, 6'sd7); send(1'b1, 11'h2AA, 6'sd5);
      send(1'b0, 11'h7FF, -6'sd3); send(1'b1, 11'h001, 6'sd7);
      rdy_val = 1'b0;
      repeat (3) @(posedge clk);
      #1; rdy_val = 1'b1;
      drain();

      // Reset while the third value is presented
      send(1'b0, 11'h100, 6'sd10); send(1'b0, 11'h200, 6'sd12);
      send(1'b1, 11'h300, 6'sd9);  send(1'b0, 11'h400, 6'sd11);
      @(posedge clk); #1;
      mon_en = 1'b0; sb.delete(); rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_exp_max", int'(exp_max), -32);
      chk("mid_rst_out_data", int'({12'd0, out_data}), 0);
      @(posedge clk); #1;
      mon_en = 1'b1;
      send(1'b1, 11'h3C0, -6'sd4); send(1'b0, 11'h011, -6'sd1);
      send(1'b0, 11'h600, -6'sd9); send(1'b1, 11'h0F0, 6'sb100000);
      drain();

      // Randomized groups with random gaps and random back-pressure
      rdy_force = 1'b0;
      for (int g = 0; g < 60; g++) begin
         base = int'($urandom_range(0, 50)) - 31;
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 4) == 0) ei = -32;
            else if ($urandom_range(0, 1) == 0) ei = int'($urandom_range(0, 62)) - 31;
            else ei = base + int'($urandom_range(0, 12));
            e = ei[5:0];
            send(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), e);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end
      drain();
      repeat (4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
